decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 128 ++++++++++++
 rtl/decode_stage_imm_gen.sv | 21 ++
 rtl/decode_stage.sv | 102 ++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, op-class and ALU-op codes, and the
// control decoder used by the decode stage (also visible to execute).
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] CLS_ALU_R  = 3'd0;
  localparam logic [2:0] CLS_ALU_I  = 3'd1;
  localparam logic [2:0] CLS_LOAD   = 3'd2;
  localparam logic [2:0] CLS_STORE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;
  localparam logic [2:0] CLS_JAL    = 3'd5;
  localparam logic [2:0] CLS_JALR   = 3'd6;
  localparam logic [2:0] CLS_UPPER  = 3'd7;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [2:0] IMM_R = 3'd0;
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [2:0] IMM_J = 3'd5;

  typedef struct packed {
    logic [2:0] op_class;
    logic [3:0] alu_op;
    logic [2:0] fmt;
    logic       use_rs1;
    logic       use_rs2;
    logic       wen_class;
    logic       illegal;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [3:0]  alu_op;
    logic [2:0]  op_class;
    logic [2:0]  funct3;
    logic        illegal;
  } id_ex_t;

  // Immediate-form shifts never become SUB; only register-form honours funct7[5] on ADD.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic f7b5,
                                             input logic is_reg);
    case (f3)
      3'd0:    alu_from_f3 = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'd1:    alu_from_f3 = ALU_SLL;
      3'd2:    alu_from_f3 = ALU_SLT;
      3'd3:    alu_from_f3 = ALU_SLTU;
      3'd4:    alu_from_f3 = ALU_XOR;
      3'd5:    alu_from_f3 = f7b5 ? ALU_SRA : ALU_SRL;
      3'd6:    alu_from_f3 = ALU_OR;
      default: alu_from_f3 = ALU_AND;
    endcase
  endfunction

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d.op_class  = CLS_ALU_R;
    d.alu_op    = ALU_ADD;
    d.fmt       = IMM_R;
    d.use_rs1   = 1'b0;
    d.use_rs2   = 1'b0;
    d.wen_class = 1'b0;
    d.illegal   = 1'b0;
    case (instr[6:0])
      OPC_OP: begin
        d.alu_op  = alu_from_f3(instr[14:12], instr[30], 1'b1);
        d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.wen_class = 1'b1;
      end
      OPC_OPIMM: begin
        d.op_class = CLS_ALU_I; d.fmt = IMM_I;
        d.alu_op   = alu_from_f3(instr[14:12], instr[30], 1'b0);
        d.use_rs1  = 1'b1; d.wen_class = 1'b1;
      end
      OPC_LOAD: begin
        d.op_class = CLS_LOAD; d.fmt = IMM_I; d.use_rs1 = 1'b1; d.wen_class = 1'b1;
      end
      OPC_STORE: begin
        d.op_class = CLS_STORE; d.fmt = IMM_S; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        d.op_class = CLS_BRANCH; d.fmt = IMM_B; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
      end
      OPC_JAL: begin
        d.op_class = CLS_JAL; d.fmt = IMM_J; d.wen_class = 1'b1;
      end
      OPC_JALR: begin
        d.op_class = CLS_JALR; d.fmt = IMM_I; d.use_rs1 = 1'b1; d.wen_class = 1'b1;
      end
      OPC_LUI: begin
        d.op_class = CLS_UPPER; d.fmt = IMM_U; d.alu_op = ALU_PASS_B; d.wen_class = 1'b1;
      end
      OPC_AUIPC: begin
        d.op_class = CLS_UPPER; d.fmt = IMM_U; d.wen_class = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// RV32I immediate generator: sign-extends from bit 31; R-type yields zero.
module imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [2:0]  fmt,
  output logic [31:0] imm
);

  always_comb begin
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the fetched word, reads operands and fills the
// ID/EX register with load-use bubble insertion and flush handling.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IF_valid,
  output logic        IF_ready,
  input  logic [31:0] IF_instr,
  input  logic [31:0] IF_pc,
  input  logic        ID_flush,
  output logic [4:0]  REGS_rdaddr1,
  output logic [4:0]  REGS_rdaddr2,
  input  logic [31:0] REGS_rddata1,
  input  logic [31:0] REGS_rddata2,
  output logic        EX_valid,
  input  logic        EX_ready,
  output logic [31:0] EX_pc,
  output logic [31:0] EX_rs1_data,
  output logic [31:0] EX_rs2_data,
  output logic [31:0] EX_imm,
  output logic [4:0]  EX_rs1,
  output logic [4:0]  EX_rs2,
  output logic [4:0]  EX_rd,
  output logic        EX_rd_wen,
  output logic [3:0]  EX_alu_op,
  output logic [2:0]  EX_op_class,
  output logic [2:0]  EX_funct3,
  output logic        EX_illegal
);

  dec_t        dec;
  id_ex_t      ex_q, ex_d;
  logic        ex_vld;
  logic [31:0] imm;
  logic        hazard, transfer;

  assign dec          = decode(IF_instr);
  assign REGS_rdaddr1 = IF_instr[19:15];
  assign REGS_rdaddr2 = IF_instr[24:20];

  imm_gen u_imm_gen (
    .instr (IF_instr),
    .fmt   (dec.fmt),
    .imm   (imm)
  );

  // Load-use only counts against rs fields the incoming format really reads.
  assign hazard = ex_vld && (ex_q.op_class == CLS_LOAD) && (ex_q.rd != 5'd0) && IF_valid &&
                  ((dec.use_rs1 && (ex_q.rd == IF_instr[19:15])) ||
                   (dec.use_rs2 && (ex_q.rd == IF_instr[24:20])));

  assign IF_ready = rst_n && (ID_flush || ((!ex_vld || EX_ready) && !hazard));
  assign transfer = IF_valid && IF_ready && !ID_flush;

  always_comb begin
    ex_d.pc       = IF_pc;
    ex_d.rs1_data = REGS_rddata1;
    ex_d.rs2_data = REGS_rddata2;
    ex_d.imm      = imm;
    ex_d.rs1      = IF_instr[19:15];
    ex_d.rs2      = IF_instr[24:20];
    ex_d.rd       = IF_instr[11:7];
    ex_d.rd_wen   = dec.wen_class && (IF_instr[11:7] != 5'd0);
    ex_d.alu_op   = dec.alu_op;
    ex_d.op_class = dec.op_class;
    ex_d.funct3   = IF_instr[14:12];
    ex_d.illegal  = dec.illegal;
  end

  // Dropping the valid bit also clears the fields forwarding logic keys on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_vld <= 1'b0;
      ex_q   <= '0;
    end else if (ID_flush || (!transfer && EX_ready)) begin
      ex_vld       <= 1'b0;
      ex_q.rd_wen  <= 1'b0;
      ex_q.illegal <= 1'b0;
      ex_q.rd      <= '0;
    end else if (transfer) begin
      ex_vld <= 1'b1;
      ex_q   <= ex_d;
    end
  end

  assign EX_valid    = ex_vld;
  assign EX_pc       = ex_q.pc;
  assign EX_rs1_data = ex_q.rs1_data;
  assign EX_rs2_data = ex_q.rs2_data;
  assign EX_imm      = ex_q.imm;
  assign EX_rs1      = ex_q.rs1;
  assign EX_rs2      = ex_q.rs2;
  assign EX_rd       = ex_q.rd;
  assign EX_rd_wen   = ex_q.rd_wen;
  assign EX_alu_op   = ex_q.alu_op;
  assign EX_op_class = ex_q.op_class;
  assign EX_funct3   = ex_q.funct3;
  assign EX_illegal  = ex_q.illegal;

endmodule
